// File: rtl/ins_loader.sv
// ---------------------------------------------------------------------------
// ins_loader
//
// Program loader that sits in front of the instruction-ROM mux. A host byte
// stream carries a 16-bit little-endian word count followed by that many
// little-endian 32-bit instruction words. Each word is written into ROM
// through the loader side of the mux. When the last word is written, ROM
// ownership passes to the RISC core.
//
// Ports
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_start_load    one-cycle request to begin a (re)load (IDLE/DONE/ERR only)
//   i_rx_data       received byte
//   i_rx_valid      one-cycle strobe qualifying i_rx_data
//   o_ins_addr_nap  ROM write byte address (loader side of the mux)
//   o_ins_data_nap  ROM write data (loader side of the mux)
//   o_we_cpu        ROM write enable, one-cycle pulse per word
//   o_sel           mux select: 0 = loader owns ROM, 1 = RISC core owns ROM
//   o_busy          loading (length or data phase)
//   o_load_done     load finished successfully
//   o_load_err      load aborted (bad length or inter-byte timeout)
//   o_word_cnt      words written in the current load
// ---------------------------------------------------------------------------
module ins_loader #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int unsigned MAX_WORDS   = 1024,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start_load,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [31:0] o_ins_addr_nap,
   output logic [31:0] o_ins_data_nap,
   output logic        o_we_cpu,
   output logic        o_sel,
   output logic        o_busy,
   output logic        o_load_done,
   output logic        o_load_err,
   output logic [15:0] o_word_cnt
);

   // The idle counter only needs to reach TIMEOUT_CYC-2: the cycle that would
   // take it to TIMEOUT_CYC-1 is the cycle that moves the FSM to ERR.
   localparam int unsigned     TmoW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 2);

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StData,
      StDone,
      StErr
   } state_e;

   state_e r_state, w_state_d;

   logic [1:0]      r_k, w_k_d;          // byte index (length: 0..1, data: 0..3)
   logic [15:0]     r_len, w_len_d;
   logic [23:0]     r_asm, w_asm_d;      // lanes 0..2 of the word being assembled
   logic [TmoW-1:0] r_tmo, w_tmo_d;
   logic [15:0]     r_word_cnt, w_cnt_d;
   logic [31:0]     r_addr, w_addr_d;
   logic [31:0]     r_data, w_data_d;
   logic            r_we, w_we_d;
   logic            r_sel, w_sel_d;
   logic            r_busy, w_busy_d;
   logic            r_done, w_done_d;
   logic            r_err, w_err_d;

   logic [31:0]     w_len_full;
   logic            w_tmo_hit;
   logic            w_last_wr;

   // Length as it will be once the second length byte lands.
   assign w_len_full = {16'd0, i_rx_data, r_len[7:0]};
   assign w_tmo_hit  = !i_rx_valid && (r_tmo == TmoLast);
   // The pulse now on the bus writes word len-1: the load completes this edge.
   assign w_last_wr  = r_we && ((r_word_cnt + 16'd1) == r_len);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin : p_state_reg
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin : p_next_state
      w_state_d = r_state;
      case (r_state)
         StIdle, StDone, StErr: begin
            if (i_start_load) begin
               w_state_d = StLen;
            end
         end
         StLen: begin
            if (w_tmo_hit) begin
               w_state_d = StErr;
            end else if (i_rx_valid && r_k[0]) begin
               if (w_len_full == 32'd0) begin
                  w_state_d = StDone;
               end else if (w_len_full > MAX_WORDS) begin
                  w_state_d = StErr;
               end else begin
                  w_state_d = StData;
               end
            end
         end
         StData: begin
            // Completion wins over a timeout landing on the same edge.
            if (w_last_wr) begin
               w_state_d = StDone;
            end else if (w_tmo_hit) begin
               w_state_d = StErr;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: registered outputs, decoded from the next state so that the flags
   // change on the same edge as the state itself.
   // ------------------------------------------------------------------------
   always_comb begin : p_outputs
      w_sel_d  = (w_state_d == StDone);
      w_busy_d = (w_state_d == StLen) || (w_state_d == StData);
      w_done_d = (w_state_d == StDone);
      w_err_d  = (w_state_d == StErr);
   end

   // ------------------------------------------------------------------------
   // Datapath next values: byte assembly, write pulse, address/count, timeout
   // ------------------------------------------------------------------------
   always_comb begin : p_datapath
      w_k_d    = r_k;
      w_len_d  = r_len;
      w_asm_d  = r_asm;
      w_tmo_d  = r_tmo;
      w_cnt_d  = r_word_cnt;
      w_addr_d = r_addr;
      w_data_d = r_data;
      w_we_d   = 1'b0;

      case (r_state)
         StIdle, StDone, StErr: begin
            if (i_start_load) begin
               w_k_d    = 2'd0;
               w_tmo_d  = '0;
               w_cnt_d  = 16'd0;
               w_addr_d = ADDR_BASE;
            end
         end
         StLen: begin
            w_tmo_d = (i_rx_valid || w_tmo_hit) ? '0 : r_tmo + TmoW'(1);
            if (i_rx_valid) begin
               if (r_k[0]) begin
                  w_len_d[15:8] = i_rx_data;
                  w_k_d         = 2'd0;
               end else begin
                  w_len_d[7:0]  = i_rx_data;
                  w_k_d         = 2'd1;
               end
            end
         end
         StData: begin
            w_tmo_d = (i_rx_valid || w_tmo_hit) ? '0 : r_tmo + TmoW'(1);
            // Advance count and address once the write pulse has been seen.
            if (r_we) begin
               w_cnt_d  = r_word_cnt + 16'd1;
               w_addr_d = r_addr + 32'd4;
            end
            // A byte in the pulse cycle is lane 0 of the next word, except
            // after the final word when the load is already complete.
            if (i_rx_valid && !w_last_wr) begin
               w_k_d = r_k + 2'd1;
               case (r_k)
                  2'd0:    w_asm_d[7:0]   = i_rx_data;
                  2'd1:    w_asm_d[15:8]  = i_rx_data;
                  2'd2:    w_asm_d[23:16] = i_rx_data;
                  default: begin
                     w_data_d = {i_rx_data, r_asm};
                     w_we_d   = 1'b1;
                  end
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin : p_regs
      if (!i_rst_n) begin
         r_k        <= 2'd0;
         r_len      <= 16'd0;
         r_asm      <= 24'd0;
         r_tmo      <= '0;
         r_word_cnt <= 16'd0;
         r_addr     <= ADDR_BASE;
         r_data     <= 32'd0;
         r_we       <= 1'b0;
         r_sel      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_k        <= w_k_d;
         r_len      <= w_len_d;
         r_asm      <= w_asm_d;
         r_tmo      <= w_tmo_d;
         r_word_cnt <= w_cnt_d;
         r_addr     <= w_addr_d;
         r_data     <= w_data_d;
         r_we       <= w_we_d;
         r_sel      <= w_sel_d;
         r_busy     <= w_busy_d;
         r_done     <= w_done_d;
         r_err      <= w_err_d;
      end
   end

   assign o_ins_addr_nap = r_addr;
   assign o_ins_data_nap = r_data;
   assign o_we_cpu       = r_we;
   assign o_sel          = r_sel;
   assign o_busy         = r_busy;
   assign o_load_done    = r_done;
   assign o_load_err     = r_err;
   assign o_word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_ins_loader.sv
// ---------------------------------------------------------------------------
// tb_ins_loader
//
// Directed bench for ins_loader. A byte-queue model predicts every output on
// every cycle; a compare process checks the DUT against it at each falling
// edge. Literal expectations on the captured ROM writes and on key flags pin
// the model to hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ins_loader;

   localparam logic [31:0] Base = 32'h0000_0000;
   localparam int unsigned MaxW = 1024;
   localparam int unsigned Tmo  = 16;

   localparam int MIdle = 0;
   localparam int MLen  = 1;
   localparam int MData = 2;
   localparam int MDone = 3;
   localparam int MErr  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_load = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [31:0] ins_addr_nap;
   logic [31:0] ins_data_nap;
   logic        we_cpu;
   logic        sel;
   logic        busy;
   logic        load_done;
   logic        load_err;
   logic [15:0] word_cnt;

   always #5 clk = ~clk;

   ins_loader #(
      .ADDR_BASE   (Base),
      .MAX_WORDS   (MaxW),
      .TIMEOUT_CYC (Tmo)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start_load   (start_load),
      .i_rx_data      (rx_data),
      .i_rx_valid     (rx_valid),
      .o_ins_addr_nap (ins_addr_nap),
      .o_ins_data_nap (ins_data_nap),
      .o_we_cpu       (we_cpu),
      .o_sel          (sel),
      .o_busy         (busy),
      .o_load_done    (load_done),
      .o_load_err     (load_err),
      .o_word_cnt     (word_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Model: bytes of the current load are queued; two make a length, four make
   // a word. A word appears on the bus the cycle after its last byte, and the
   // count/address advance the cycle after that.
   // ------------------------------------------------------------------------
   int               m_mode;
   byte unsigned     m_q[$];
   int unsigned      m_len;
   int unsigned      m_cnt;
   int unsigned      m_idle;
   logic [31:0]      m_addr;
   logic [31:0]      m_data;
   logic             m_we;
   logic             m_wrote;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_mode = MIdle;
         m_q.delete();
         m_len  = 0;
         m_cnt  = 0;
         m_idle = 0;
         m_addr = Base;
         m_data = 32'd0;
         m_we   = 1'b0;
      end else begin
         m_wrote = m_we;
         m_we    = 1'b0;
         if (m_mode == MIdle || m_mode == MDone || m_mode == MErr) begin
            if (start_load) begin
               m_mode = MLen;
               m_q.delete();
               m_cnt  = 0;
               m_idle = 0;
               m_addr = Base;
            end
         end else begin
            if (m_wrote) begin
               m_cnt++;
               m_addr = m_addr + 32'd4;
            end
            if (m_wrote && m_cnt == m_len) begin
               m_mode = MDone;
            end else if (rx_valid) begin
               m_idle = 0;
               m_q.push_back(rx_data);
               if (m_mode == MLen && m_q.size() == 2) begin
                  m_len = {16'd0, m_q[1], m_q[0]};
                  m_q.delete();
                  if (m_len == 0)         m_mode = MDone;
                  else if (m_len > MaxW)  m_mode = MErr;
                  else                    m_mode = MData;
               end else if (m_mode == MData && m_q.size() == 4) begin
                  m_data = {m_q[3], m_q[2], m_q[1], m_q[0]};
                  m_q.delete();
                  m_we   = 1'b1;
               end
            end else begin
               m_idle++;
               if (m_idle >= Tmo - 1) m_mode = MErr;
            end
         end
      end
   end

   // Captured ROM writes.
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   function automatic logic [31:0] wa(input int i);
      if (i < wr_addr.size()) return wr_addr[i];
      return 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] wd(input int i);
      if (i < wr_data.size()) return wr_data[i];
      return 32'hxxxx_xxxx;
   endfunction

   // Compare process: every cycle, every output.
   initial forever begin
      @(negedge clk);
      if (we_cpu) begin
         wr_addr.push_back(ins_addr_nap);
         wr_data.push_back(ins_data_nap);
      end
      check("cyc_we",     {31'd0, we_cpu},    {31'd0, m_we});
      check("cyc_sel",    {31'd0, sel},       {31'd0, m_mode == MDone});
      check("cyc_busy",   {31'd0, busy},      {31'd0, m_mode == MLen || m_mode == MData});
      check("cyc_done",   {31'd0, load_done}, {31'd0, m_mode == MDone});
      check("cyc_err",    {31'd0, load_err},  {31'd0, m_mode == MErr});
      check("cyc_cnt",    {16'd0, word_cnt},  m_cnt);
      check("cyc_addr",   ins_addr_nap,       m_addr);
      check("cyc_data",   ins_data_nap,       m_data);
      check("cyc_sel_we", {31'd0, sel & we_cpu}, 32'd0);
   end

   task automatic drive(input logic st, input logic v, input logic [7:0] d);
      @(negedge clk);
      start_load = st;
      rx_valid   = v;
      rx_data    = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_gap(input logic [7:0] b);
      drive(1'b0, 1'b1, b);
      drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b);
      drive(1'b0, 1'b1, b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int tmo_seen;
   int we_seen;

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_addr", ins_addr_nap, Base);
      check("rst_data", ins_data_nap, 32'd0);
      check("rst_sel",  {31'd0, sel}, 32'd0);
      check("rst_cnt",  {16'd0, word_cnt}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Basic two-word load with gaps between bytes
      drive(1'b1, 1'b0, 8'h00);
      send_gap(8'h02); send_gap(8'h00);
      send_gap(8'h13); send_gap(8'h00); send_gap(8'h00); send_gap(8'h00);
      send_gap(8'h93); send_gap(8'h00); send_gap(8'h10); send_gap(8'h00);
      idle(4);
      check("basic_nwr",  wr_addr.size(), 32'd2);
      check("basic_a0",   wa(0), 32'h0000_0000);
      check("basic_d0",   wd(0), 32'h0000_0013);
      check("basic_a1",   wa(1), 32'h0000_0004);
      check("basic_d1",   wd(1), 32'h0010_0093);
      check("basic_cnt",  {16'd0, word_cnt}, 32'd2);
      check("basic_done", {31'd0, load_done}, 32'd1);
      check("basic_sel",  {31'd0, sel}, 32'd1);

      // Reload from DONE with back-to-back bytes, three words
      drive(1'b1, 1'b0, 8'h00);
      send(8'h03);
      check("reload_sel",  {31'd0, sel}, 32'd0);
      check("reload_addr", ins_addr_nap, Base);
      check("reload_busy", {31'd0, busy}, 32'd1);
      send(8'h00);
      send(8'h44); send(8'h33); send(8'h22); send(8'h11);
      send(8'hef); send(8'hbe); send(8'had); send(8'hde);
      send(8'h0d); send(8'hf0); send(8'had); send(8'h0b);
      idle(4);
      check("b2b_nwr", wr_addr.size(), 32'd5);
      check("b2b_a0",  wa(2), 32'h0000_0000);
      check("b2b_d0",  wd(2), 32'h1122_3344);
      check("b2b_a1",  wa(3), 32'h0000_0004);
      check("b2b_d1",  wd(3), 32'hdead_beef);
      check("b2b_a2",  wa(4), 32'h0000_0008);
      check("b2b_d2",  wd(4), 32'h0bad_f00d);
      check("b2b_cnt", {16'd0, word_cnt}, 32'd3);

      // Zero length
      drive(1'b1, 1'b0, 8'h00);
      send(8'h00); send(8'h00);
      idle(3);
      check("zero_done", {31'd0, load_done}, 32'd1);
      check("zero_sel",  {31'd0, sel}, 32'd1);
      check("zero_cnt",  {16'd0, word_cnt}, 32'd0);
      check("zero_nwr",  wr_addr.size(), 32'd5);

      // Oversize length (1025)
      drive(1'b1, 1'b0, 8'h00);
      send(8'h01); send(8'h04);
      idle(3);
      check("big_err",  {31'd0, load_err}, 32'd1);
      check("big_sel",  {31'd0, sel}, 32'd0);
      check("big_busy", {31'd0, busy}, 32'd0);
      check("big_nwr",  wr_addr.size(), 32'd5);

      // Timeout: one-word load, two data bytes, then silence
      drive(1'b1, 1'b0, 8'h00);
      send(8'h01);
      check("tmo_errclr", {31'd0, load_err}, 32'd0);
      send(8'h00); send(8'haa); send(8'hbb);
      tmo_seen = 0;
      for (int i = 1; i <= 40; i++) begin
         drive(1'b0, 1'b0, 8'h00);
         if (load_err) begin
            tmo_seen = i;
            break;
         end
      end
      check("tmo_cycles", tmo_seen, 32'd16);
      check("tmo_nwr",    wr_addr.size(), 32'd5);
      check("tmo_sel",    {31'd0, sel}, 32'd0);

      // Restart from ERR clears the error and loads normally
      drive(1'b1, 1'b0, 8'h00);
      send(8'h01);
      check("err_restart_err",  {31'd0, load_err}, 32'd0);
      check("err_restart_busy", {31'd0, busy}, 32'd1);
      send(8'h00);
      send(8'hfe); send(8'hca); send(8'had); send(8'h0b);
      idle(4);
      check("rel_nwr",  wr_addr.size(), 32'd6);
      check("rel_a",    wa(5), 32'h0000_0000);
      check("rel_d",    wd(5), 32'h0bad_cafe);
      check("rel_done", {31'd0, load_done}, 32'd1);

      // Reset while a write pulse is on the bus
      drive(1'b1, 1'b0, 8'h00);
      send(8'h02); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      drive(1'b0, 1'b0, 8'h00);
      we_seen = we_cpu ? 1 : 0;
      check("mid_we_before", we_seen, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_we",   {31'd0, we_cpu}, 32'd0);
      check("mid_sel",  {31'd0, sel}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_addr", ins_addr_nap, Base);
      check("mid_data", ins_data_nap, 32'd0);
      check("mid_cnt",  {16'd0, word_cnt}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Clean load after reset
      drive(1'b1, 1'b0, 8'h00);
      send(8'h01); send(8'h00);
      send(8'h04); send(8'h03); send(8'h02); send(8'h01);
      idle(4);
      check("post_nwr",  wr_addr.size(), 32'd8);
      check("post_a",    wa(7), 32'h0000_0000);
      check("post_d",    wd(7), 32'h0102_0304);
      check("post_cnt",  {16'd0, word_cnt}, 32'd1);
      check("post_done", {31'd0, load_done}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
- Program-loader stage directly upstream of the instruction-ROM mux.
- Receives a byte stream from the host receiver, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction ROM through the loader ("nap") side of the mux.
- Drives the mux select: holds ROM ownership on the loader side while loading, then hands it to the RISC core when loading finishes.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 1024, largest accepted word count; any larger count is an error.
- TIMEOUT_CYC, 1_000_000, maximum number of idle clock cycles allowed between bytes while a load is in progress.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_load  in  1  single-cycle request to begin a (re)load.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- ins_addr_nap  out  32  ROM write byte address (to mux loader side).
- ins_data_nap  out  32  ROM write data (to mux loader side).
- we_cpu  out  1  ROM write enable (to mux loader side); a one-cycle pulse per word.
- sel  out  1  mux select: 0 = loader owns ROM, 1 = RISC core owns ROM.
- busy  out  1  high in the LEN and DATA states.
- load_done  out  1  high in the DONE state.
- load_err  out  1  high in the ERR state.
- word_cnt  out  16  number of words written in the current load.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ins_addr_nap=ADDR_BASE, ins_data_nap=0, we_cpu=0.
  - sel=0, busy=0, load_done=0, load_err=0, word_cnt=0.
  - Byte index, length register and timeout counter all cleared.
- All outputs are registered. State transitions happen on the rising edge of clk.
- IDLE:
  - start_load=1 → LEN.
  - rx_valid is ignored.
- LEN:
  - Accepts 2 bytes, little-endian, into len[15:0].
  - On the 2nd byte:
    - len=0 → DONE.
    - len>MAX_WORDS → ERR.
    - otherwise → DATA.
- DATA:
  - Each rx_valid byte fills byte lane k of the assembly word (k=0..3, lane 0 = bits[7:0]).
  - On the byte with k=3, accepted in cycle N:
    - Cycle N+1: we_cpu=1, ins_data_nap=assembled word, ins_addr_nap=ADDR_BASE+4*word_cnt.
    - Cycle N+2: we_cpu=0, word_cnt+1, ins_addr_nap+4.
  - A byte arriving in cycle N+1 is accepted normally as lane 0 of the next word. No byte is ever dropped.
  - When the write pulse is for word len-1 → DONE at cycle N+2. sel=1 from cycle N+2; it is never high while we_cpu=1.
- DONE:
  - sel=1, load_done=1; word_cnt holds its value.
  - start_load=1 → LEN; sel returns to 0 on the next edge and word_cnt, k and ins_addr_nap reset.
- ERR:
  - sel=0, load_err=1, we_cpu=0.
  - start_load=1 → LEN with load_err cleared.
- start_load in LEN or DATA is ignored; a load cannot be restarted mid-transfer.
- Timeout (LEN and DATA only):
  - The counter clears on every rx_valid and increments otherwise.
  - Reaching TIMEOUT_CYC-1 → ERR. A partially assembled word is discarded and not written.
- ins_addr_nap wraps modulo 2^32. word_cnt cannot overflow because of the MAX_WORDS check.
- Reset mid-load: the state returns to IDLE immediately and sel=0. Any write pulse in flight is cancelled asynchronously.

Test Plan:
- Basic load: start_load, then bytes 02 00 | 13 00 00 00 | 93 00 10 00 → we_cpu pulses writing 0x00000013@0x0 and 0x00100093@0x4; sel=1 the cycle after the 2nd pulse; word_cnt=2; load_done=1.
- Back-to-back bytes: rx_valid held high every cycle for a 3-word load → exactly 3 write pulses with correct data; no byte lost in the cycle after a write pulse.
- Zero and oversize length: len=0 → DONE immediately with no write and sel=1. len=1025 (MAX_WORDS=1024) → load_err=1, sel=0, no write.
- Timeout: TIMEOUT_CYC=16, send len=1 plus 2 data bytes, then stop → ERR after 15 idle cycles, no write; a following start_load clears load_err.
- Reload: start_load in DONE → sel=0 on the next edge, ins_addr_nap=ADDR_BASE, and new words overwrite from the base address.
- Reset mid-load: assert rst_n=0 during the DATA state → all outputs at reset values asynchronously, and the next load starts cleanly.
